decoder_2to4: RTL and testbench

Registered 2-to-4 one-hot decoder that drives the four digit-enable lines of the multiplexed 7-segment stopwatch display. It sits between the digit-scan counter (which supplies the 2-bit digit select) and the display anode pins. An optional blanking interval keeps all digits dark between digit switches to suppress ghosting. An optional output inversion supports common-anode hardware.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/decoder_2to4_onehot.sv | 13 +
 rtl/decoder_2to4.sv | 82 ++++++++
 tb/tb_decoder_2to4.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, FSM state type and select normalisation for the digit-enable decoder
package decoder_pkg;
    localparam int SEL_W   = 2;
    localparam int NUM_OUT = 4;
    localparam int CNT_W   = 8;
    typedef enum logic [1:0] {S_OFF, S_BLANK, S_ON} state_e;
    function automatic logic [SEL_W-1:0] norm_sel(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r;
        case (s)
            2'b00:   r = 2'b00;
            2'b01:   r = 2'b01;
            2'b10:   r = 2'b10;
            default: r = 2'b11;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/decoder_2to4_onehot.sv
// onehot_dec_2to4: combinational 2-bit to 4-bit one-hot decode, bit 0 = digit 1
module onehot_dec_2to4
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] dec_o
);
    always_comb begin
        dec_o = (sel_i == 2'b00) ? 4'b0001 :
                (sel_i == 2'b01) ? 4'b0010 :
                (sel_i == 2'b10) ? 4'b0100 : 4'b1000;
    end
endmodule

// File: rtl/decoder_2to4.sv
// decoder_2to4: registered one-hot digit-enable decoder with optional blanking and output inversion
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b0,
    parameter int unsigned BLANK_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_out1,
    output logic             o_out2,
    output logic             o_out3,
    output logic             o_out4
);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);
    localparam bit               NO_BLANK = (BLANK_CYCLES == 0);
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d, sel_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] out_q, out_d, dec;
    logic               changed;
    assign sel_n   = norm_sel(i_sel);
    assign changed = (sel_n != tgt_q);
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (i_en) begin
                    tgt_d   = sel_n;
                    cnt_d   = NO_BLANK ? cnt_q : BLANK_LD;
                    state_d = NO_BLANK ? S_ON : S_BLANK;
                end
            end
            S_BLANK: begin
                if (!i_en) begin
                    state_d = S_OFF;
                end else if (changed) begin
                    tgt_d = sel_n;
                    cnt_d = BLANK_LD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ON: begin
                if (!i_en) begin
                    state_d = S_OFF;
                end else if (changed) begin
                    tgt_d   = sel_n;
                    cnt_d   = NO_BLANK ? cnt_q : BLANK_LD;
                    state_d = NO_BLANK ? S_ON : S_BLANK;
                end
            end
            default: state_d = S_OFF;
        endcase
    end
    onehot_dec_2to4 u_dec (
        .sel_i (tgt_d),
        .dec_o (dec)
    );
    // Output register is loaded from next state so outputs track the FSM with no extra cycle
    assign out_d = (state_d == S_ON) ? dec : '0;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_OFF;
            tgt_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end
    assign {o_out4, o_out3, o_out2, o_out1} = out_q ^ {NUM_OUT{ACTIVE_LOW}};
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: directed checks of decode, blanking, enable, polarity and reset behaviour
module tb_decoder_2to4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] sel = 2'b00;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] v0, v3, v5, vl;
    logic a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4, d1, d2, d3, d4;
    always #5 clk = ~clk;
    decoder_2to4 #(.ACTIVE_LOW(1'b0), .BLANK_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sel(sel),
        .o_out1(a1), .o_out2(a2), .o_out3(a3), .o_out4(a4));
    decoder_2to4 #(.ACTIVE_LOW(1'b0), .BLANK_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sel(sel),
        .o_out1(b1), .o_out2(b2), .o_out3(b3), .o_out4(b4));
    decoder_2to4 #(.ACTIVE_LOW(1'b0), .BLANK_CYCLES(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sel(sel),
        .o_out1(c1), .o_out2(c2), .o_out3(c3), .o_out4(c4));
    decoder_2to4 #(.ACTIVE_LOW(1'b1), .BLANK_CYCLES(2)) dutl (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sel(sel),
        .o_out1(d1), .o_out2(d2), .o_out3(d3), .o_out4(d4));
    // Vectors read o_out1..o_out4 left to right
    assign v0 = {a1, a2, a3, a4};
    assign v3 = {b1, b2, b3, b4};
    assign v5 = {c1, c2, c3, c4};
    assign vl = {d1, d2, d3, d4};
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_reset;
        rst = 1'b1; en = 1'b1; sel = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (v0 !== 4'b0000 || v3 !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold%0d: b0=%b b3=%b, want 0000 0000", i, v0, v3);
            end
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (v0 !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 0010", v0);
        end
    endtask
    task automatic test_sweep;
        logic [3:0] exp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            n_chk++;
            if (v0 !== exp[i] || !$onehot(v0)) begin
                n_fail++;
                $display("FAIL sweep_sel%0d: got %b want %b", i, v0, exp[i]);
            end
        end
    endtask
    task automatic test_blank;
        logic [3:0] exp1 [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
        logic [3:0] exp2 [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        en = 1'b1; sel = 2'b00;
        tick(5);
        n_chk++;
        if (v3 !== 4'b1000) begin
            n_fail++;
            $display("FAIL blank_steady: got %b want 1000", v3);
        end
        sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (v3 !== exp1[i]) begin
                n_fail++;
                $display("FAIL blank_step%0d: got %b want %b", i, v3, exp1[i]);
            end
        end
        sel = 2'b00;
        tick(5);
        sel = 2'b01;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) sel = 2'b10;
            tick();
            n_chk++;
            if (v3 !== exp2[i]) begin
                n_fail++;
                $display("FAIL blank_restart%0d: got %b want %b", i, v3, exp2[i]);
            end
        end
    endtask
    task automatic test_enable;
        logic [3:0] exp3 [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
        en = 1'b1; sel = 2'b11;
        tick(5);
        n_chk++;
        if (v0 !== 4'b0001 || v3 !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_steady: b0=%b b3=%b want 0001 0001", v0, v3);
        end
        en = 1'b0;
        tick();
        n_chk++;
        if (v0 !== 4'b0000 || v3 !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_fall: b0=%b b3=%b want 0000 0000", v0, v3);
        end
        en = 1'b1; sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (v3 !== exp3[i] || v0 !== 4'b1000) begin
                n_fail++;
                $display("FAIL en_rise%0d: b0=%b b3=%b want 1000 %b", i, v0, v3, exp3[i]);
            end
        end
        en = 1'b0; sel = 2'b10;
        tick();
        n_chk++;
        if (v0 !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_wins: got %b want 0000", v0);
        end
    endtask
    task automatic test_active_low;
        logic [3:0] expl [3] = '{4'b1111, 4'b1111, 4'b1011};
        rst = 1'b1; en = 1'b1; sel = 2'b01;
        tick();
        n_chk++;
        if (vl !== 4'b1111) begin
            n_fail++;
            $display("FAIL al_reset: got %b want 1111", vl);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (vl !== expl[i]) begin
                n_fail++;
                $display("FAIL al_step%0d: got %b want %b", i, vl, expl[i]);
            end
        end
    endtask
    task automatic test_reset_mid_blank;
        en = 1'b1; sel = 2'b00;
        tick(7);
        n_chk++;
        if (v5 !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_steady: got %b want 1000", v5);
        end
        sel = 2'b01;
        tick(2);
        rst = 1'b1;
        tick();
        n_chk++;
        if (v5 !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0000", v5);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++;
            if (v5 !== ((i == 5) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("FAIL mid_reblank%0d: got %b want %b", i, v5, (i == 5) ? 4'b0100 : 4'b0000);
            end
        end
    endtask
    initial begin
        test_reset();
        test_sweep();
        test_blank();
        test_enable();
        test_active_low();
        test_reset_mid_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
